// File: rtl/exec_sequencer.sv
// Multi-cycle bytecode instruction sequencer: fetch, decode, inline-argument
// collection, operand pops, execution hand-off, result push and branch resolution.
module exec_sequencer #(
  parameter int PC_WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic [PC_WIDTH-1:0] progaddr,
  input  logic [7:0]          progdata,
  output logic [7:0]          opcode,
  input  logic [1:0]          argc,
  input  logic [1:0]          stackargs,
  input  logic                stackwb,
  input  logic                isgoto,
  input  logic                iscmp,
  output logic [15:0]         args,
  output logic [31:0]         op0,
  output logic [31:0]         op1,
  output logic [31:0]         op2,
  output logic                pop,
  input  logic [31:0]         popdata,
  output logic                execstart,
  input  logic                execdone,
  input  logic [31:0]         execresult,
  input  logic                branchtaken,
  output logic                push,
  output logic [31:0]         pushdata,
  output logic                running,
  output logic                halted
);

  // state  | meaning
  // IDLE   | waiting for start after reset
  // FETCH  | opcode address on progaddr
  // DECODE | opcode byte arrives, decoder fields latched
  // ARG    | collecting inline argument bytes
  // POP    | popping operands into op0..op2
  // EXEC   | execution units running
  // WB     | pushing latched result
  // NEXT   | pc update (sequential or branch)
  // HALT   | return executed, pc held
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_ARG, S_POP, S_EXEC, S_WB, S_NEXT, S_HALT
  } state_t;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q;
  logic [7:0]          opcode_q;
  logic [1:0]          argc_q;
  logic [1:0]          stackargs_q;
  logic                stackwb_q;
  logic                isgoto_q;
  logic                iscmp_q;
  logic                taken_q;
  logic [1:0]          argcnt_q;
  logic [1:0]          popcnt_q;
  logic                exec_busy_q;
  logic                is_return;
  logic [PC_WIDTH-1:0] offset;

  assign is_return = progdata inside {8'hac, 8'hb0, 8'hb1};

  // Branch offset is a signed 16-bit quantity fitted to the pc width.
  generate
    if (PC_WIDTH > 16) begin : g_sext
      assign offset = {{(PC_WIDTH-16){args[15]}}, args};
    end else begin : g_trunc
      assign offset = args[PC_WIDTH-1:0];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    progaddr  = pc_q;
    pop       = 1'b0;
    push      = 1'b0;
    execstart = 1'b0;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        progaddr = pc_q + PC_WIDTH'(1);
        if (is_return)            state_d = S_HALT;
        else if (argc != 2'd0)      state_d = S_ARG;
        else if (stackargs != 2'd0) state_d = S_POP;
        else                        state_d = S_EXEC;
      end
      S_ARG: begin
        progaddr = pc_q + PC_WIDTH'(2) + PC_WIDTH'(argcnt_q);
        if (argcnt_q + 2'd1 == argc_q)
          state_d = (stackargs_q != 2'd0) ? S_POP : S_EXEC;
      end
      S_POP: begin
        pop = 1'b1;
        if (popcnt_q + 2'd1 == stackargs_q) state_d = S_EXEC;
      end
      S_EXEC: begin
        execstart = !exec_busy_q;
        if (execdone) state_d = stackwb_q ? S_WB : S_NEXT;
      end
      S_WB: begin
        push    = 1'b1;
        state_d = S_NEXT;
      end
      S_NEXT:  state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= '0;
      opcode_q    <= 8'h00;
      argc_q      <= 2'd0;
      stackargs_q <= 2'd0;
      stackwb_q   <= 1'b0;
      isgoto_q    <= 1'b0;
      iscmp_q     <= 1'b0;
      taken_q     <= 1'b0;
      argcnt_q    <= 2'd0;
      popcnt_q    <= 2'd0;
      exec_busy_q <= 1'b0;
      args        <= 16'h0000;
      op0         <= 32'h0;
      op1         <= 32'h0;
      op2         <= 32'h0;
      pushdata    <= 32'h0;
    end else begin
      case (state_q)
        S_IDLE, S_HALT: begin
          if (start) pc_q <= '0;
        end
        S_DECODE: begin
          opcode_q    <= progdata;
          argc_q      <= argc;
          stackargs_q <= stackargs;
          stackwb_q   <= stackwb;
          isgoto_q    <= isgoto;
          iscmp_q     <= iscmp;
          args        <= 16'h0000;
          argcnt_q    <= 2'd0;
          popcnt_q    <= 2'd0;
        end
        S_ARG: begin
          args     <= {args[7:0], progdata};
          argcnt_q <= argcnt_q + 2'd1;
        end
        S_POP: begin
          case (popcnt_q)
            2'd0:    op0 <= popdata;
            2'd1:    op1 <= popdata;
            2'd2:    op2 <= popdata;
            default: ;
          endcase
          popcnt_q <= popcnt_q + 2'd1;
        end
        S_EXEC: begin
          // exec_busy_q keeps execstart to a single pulse while stalled
          if (execdone) begin
            pushdata    <= execresult;
            taken_q     <= branchtaken;
            exec_busy_q <= 1'b0;
          end else begin
            exec_busy_q <= 1'b1;
          end
        end
        S_NEXT: begin
          if (isgoto_q || (iscmp_q && taken_q))
            pc_q <= pc_q + offset;
          else
            pc_q <= pc_q + PC_WIDTH'(1) + PC_WIDTH'(argc_q);
        end
        default: ;
      endcase
    end
  end

  assign opcode  = (state_q == S_DECODE) ? progdata : opcode_q;
  assign running = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted  = (state_q == S_HALT);

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer: ROM, decoder, operand stack and execution
// unit models around the DUT, single-instruction vectors plus corner sequences.
module tb_exec_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] progaddr;
  logic [7:0]  progdata = 8'h00;
  logic [7:0]  opcode;
  logic [1:0]  argc, stackargs;
  logic        stackwb, isgoto, iscmp;
  logic [15:0] args;
  logic [31:0] op0, op1, op2;
  logic        pop;
  logic [31:0] popdata;
  logic        execstart;
  logic        execdone;
  logic [31:0] execresult;
  logic        branchtaken;
  logic        push;
  logic [31:0] pushdata;
  logic        running, halted;

  exec_sequencer #(.PC_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .progaddr(progaddr), .progdata(progdata),
    .opcode(opcode), .argc(argc), .stackargs(stackargs), .stackwb(stackwb),
    .isgoto(isgoto), .iscmp(iscmp), .args(args), .op0(op0), .op1(op1), .op2(op2),
    .pop(pop), .popdata(popdata), .execstart(execstart), .execdone(execdone),
    .execresult(execresult), .branchtaken(branchtaken), .push(push),
    .pushdata(pushdata), .running(running), .halted(halted)
  );

  always #5 clk = ~clk;

  // Program ROM, one-cycle latency
  logic [7:0] rom [0:65535];
  always @(posedge clk) progdata <= rom[progaddr];

  // Decoder
  always_comb begin
    argc = 2'd0; stackargs = 2'd0; stackwb = 1'b0; isgoto = 1'b0; iscmp = 1'b0;
    case (opcode)
      8'h10: begin argc = 2'd1; stackwb = 1'b1; end
      8'h11: begin argc = 2'd2; stackwb = 1'b1; end
      8'h60, 8'h68: begin stackargs = 2'd2; stackwb = 1'b1; end
      8'h4f: stackargs = 2'd3;
      8'ha7: begin argc = 2'd2; isgoto = 1'b1; end
      8'ha1: begin argc = 2'd2; stackargs = 2'd2; iscmp = 1'b1; end
      default: ;
    endcase
  end

  // Operand stack
  logic [31:0] pv [0:3];
  logic [1:0]  pop_idx;
  always @(posedge clk or posedge rst)
    if (rst) pop_idx <= 2'd0;
    else if (pop) pop_idx <= pop_idx + 2'd1;
  assign popdata = pv[pop_idx];

  // Execution unit with programmable latency
  logic [31:0] exec_val = 32'h0;
  logic        bt_val = 1'b0;
  int          exec_delay = 0;
  logic        ex_busy;
  int          ex_cnt;
  always @(posedge clk or posedge rst)
    if (rst) begin ex_busy <= 1'b0; ex_cnt <= 0; end
    else if (execstart && !execdone) begin ex_busy <= 1'b1; ex_cnt <= exec_delay - 1; end
    else if (ex_busy) begin
      if (ex_cnt == 0) ex_busy <= 1'b0;
      else ex_cnt <= ex_cnt - 1;
    end
  assign execdone    = (execstart && exec_delay == 0) || (ex_busy && ex_cnt == 0);
  assign execresult  = exec_val;
  assign branchtaken = bt_val;

  // Activity monitor
  int          run_cnt, es_cnt, pop_cnt, push_cnt, overlap;
  logic [31:0] last_push, cap_op0, cap_op1, cap_op2;
  logic [15:0] cap_args;
  always @(negedge clk) begin
    if (rst) begin
      run_cnt = 0; es_cnt = 0; pop_cnt = 0; push_cnt = 0; overlap = 0;
      last_push = 0; cap_args = 0; cap_op0 = 0; cap_op1 = 0; cap_op2 = 0;
    end else begin
      if (running) run_cnt++;
      if (execstart) begin
        es_cnt++; cap_args = args; cap_op0 = op0; cap_op1 = op1; cap_op2 = op2;
      end
      if (pop) pop_cnt++;
      if (push) begin push_cnt++; last_push = pushdata; end
      if (pop && push) overlap++;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic fill_rom();
    for (int a = 0; a < 65536; a++) rom[a] = 8'hb1;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_halt(input string name);
    int n = 0;
    while (!halted && n < 300) begin @(negedge clk); n++; end
    chk({name, "_halt_timeout"}, {31'd0, halted}, 32'd1);
  endtask

  typedef struct {
    logic [15:0] base;
    int          len;
    logic [7:0]  b0, b1, b2;
    logic [31:0] p0, p1, p2;
    logic [31:0] res;
    logic        bt;
    int          delay;
    logic        mid_start;
    int          exp_cyc;
    logic [15:0] exp_pc;
    int          exp_pops;
    int          exp_pushes;
    logic [31:0] exp_push;
    logic [15:0] exp_args;
    logic [31:0] exp_op0, exp_op1, exp_op2;
  } vec_t;

  vec_t vecs [0:10];

  task automatic run_vec(input vec_t v, input int i);
    int pre;
    int n;
    string p;
    p = $sformatf("v%0d", i);
    fill_rom();
    pre = (v.base != 16'h0) ? 6 : 0;
    if (v.base != 16'h0) begin
      rom[0] = 8'ha7; rom[1] = v.base[15:8]; rom[2] = v.base[7:0];
    end
    rom[v.base] = v.b0;
    if (v.len > 1) rom[v.base + 16'd1] = v.b1;
    if (v.len > 2) rom[v.base + 16'd2] = v.b2;
    pv[0] = v.p0; pv[1] = v.p1; pv[2] = v.p2; pv[3] = 32'h0;
    exec_val = v.res; bt_val = v.bt; exec_delay = v.delay;
    do_reset();
    pulse_start();
    n = 0;
    while (!halted && n < 300) begin
      @(negedge clk);
      start = v.mid_start && (n == 4);
      n++;
    end
    start = 1'b0;
    chk({p, "_halted"},   {31'd0, halted}, 32'd1);
    chk({p, "_pc"},       {16'd0, progaddr}, {16'd0, v.exp_pc});
    chk({p, "_opcode"},   {24'd0, opcode}, 32'h000000b1);
    chk({p, "_cycles"},   run_cnt, v.exp_cyc + pre + 2);
    chk({p, "_execstart"}, es_cnt, (pre != 0) ? 2 : 1);
    chk({p, "_pops"},     pop_cnt, v.exp_pops);
    chk({p, "_pushes"},   push_cnt, v.exp_pushes);
    chk({p, "_pushdata"}, last_push, v.exp_push);
    chk({p, "_args"},     {16'd0, cap_args}, {16'd0, v.exp_args});
    chk({p, "_op0"},      cap_op0, v.exp_op0);
    chk({p, "_op1"},      cap_op1, v.exp_op1);
    chk({p, "_op2"},      cap_op2, v.exp_op2);
    chk({p, "_pop_push_overlap"}, overlap, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int n;
    fill_rom();
    pv[0] = 0; pv[1] = 0; pv[2] = 0; pv[3] = 0;
    do_reset();
    #1;
    chk("rst_progaddr", {16'd0, progaddr}, 32'd0);
    chk("rst_opcode", {24'd0, opcode}, 32'd0);
    chk("rst_args", {16'd0, args}, 32'd0);
    chk("rst_ops", op0 | op1 | op2, 32'd0);
    chk("rst_pushdata", pushdata, 32'd0);
    chk("rst_strobes", {27'd0, pop, push, execstart, running, halted}, 32'd0);

    //          base   len b0     b1     b2     p0 p1 p2 res       bt delay mid cyc pc       pops pushes push     args      op0 op1 op2
    vecs[0]  = '{16'h0000, 1, 8'h00, 8'h00, 8'h00, 0, 0, 0, 32'd0,    1'b0, 0, 1'b0, 4,  16'h0001, 0, 0, 32'd0,    16'h0000, 0, 0, 0};
    vecs[1]  = '{16'h0000, 2, 8'h10, 8'h2a, 8'h00, 0, 0, 0, 32'd42,   1'b0, 0, 1'b0, 6,  16'h0002, 0, 1, 32'd42,   16'h002a, 0, 0, 0};
    vecs[2]  = '{16'h0000, 1, 8'h60, 8'h00, 8'h00, 7, 5, 0, 32'd12,   1'b0, 0, 1'b0, 7,  16'h0001, 2, 1, 32'd12,   16'h0000, 7, 5, 0};
    vecs[3]  = '{16'h0000, 3, 8'h11, 8'h12, 8'h34, 0, 0, 0, 32'h1234, 1'b0, 0, 1'b0, 7,  16'h0003, 0, 1, 32'h1234, 16'h1234, 0, 0, 0};
    vecs[4]  = '{16'h0000, 3, 8'ha7, 8'h00, 8'h05, 0, 0, 0, 32'd0,    1'b0, 0, 1'b0, 6,  16'h0005, 0, 0, 32'd0,    16'h0005, 0, 0, 0};
    vecs[5]  = '{16'h0010, 3, 8'ha7, 8'hff, 8'hfd, 0, 0, 0, 32'd0,    1'b0, 0, 1'b0, 6,  16'h000d, 0, 0, 32'd0,    16'hfffd, 0, 0, 0};
    vecs[6]  = '{16'h0020, 3, 8'ha1, 8'h00, 8'h08, 3, 9, 0, 32'd0,    1'b1, 0, 1'b0, 8,  16'h0028, 2, 0, 32'd0,    16'h0008, 3, 9, 0};
    vecs[7]  = '{16'h0020, 3, 8'ha1, 8'h00, 8'h08, 3, 9, 0, 32'd0,    1'b0, 0, 1'b0, 8,  16'h0023, 2, 0, 32'd0,    16'h0008, 3, 9, 0};
    vecs[8]  = '{16'h0000, 1, 8'h4f, 8'h00, 8'h00, 1, 2, 3, 32'd0,    1'b0, 0, 1'b0, 7,  16'h0001, 3, 0, 32'd0,    16'h0000, 1, 2, 3};
    vecs[9]  = '{16'h0000, 1, 8'hff, 8'h00, 8'h00, 0, 0, 0, 32'd0,    1'b0, 0, 1'b0, 4,  16'h0001, 0, 0, 32'd0,    16'h0000, 0, 0, 0};
    vecs[10] = '{16'h0000, 1, 8'h68, 8'h00, 8'h00, 6, 7, 0, 32'd42,   1'b0, 5, 1'b1, 12, 16'h0001, 2, 1, 32'd42,   16'h0000, 6, 7, 0};

    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

    // GOTO wrap: NOP at 0, GOTO -3 at 1 -> 0xfffe, GOTO +3 at 0xfffe -> 0x0001
    fill_rom();
    rom[0] = 8'h03; rom[1] = 8'ha7; rom[2] = 8'hff; rom[3] = 8'hfd;
    rom[16'hfffe] = 8'ha7; rom[16'hffff] = 8'h00;
    exec_val = 0; bt_val = 1'b0; exec_delay = 0;
    do_reset();
    pulse_start();
    for (int k = 2; k <= 17; k++) begin
      @(negedge clk);
      if (k == 11) chk("wrap_fetch_fffe", {16'd0, progaddr}, 32'h0000fffe);
      if (k == 17) begin
        chk("wrap_fetch_0001", {16'd0, progaddr}, 32'h00000001);
        chk("wrap_args", {16'd0, cap_args}, 32'h00000003);
      end
    end

    // Reset during the second pop of IADD, then rerun and restart from HALT
    fill_rom();
    rom[0] = 8'h60;
    pv[0] = 7; pv[1] = 5; pv[2] = 0; pv[3] = 0;
    exec_val = 12; exec_delay = 0;
    do_reset();
    pulse_start();
    n = 0;
    while (!pop && n < 20) begin @(negedge clk); n++; end
    chk("midpop_first_pop", {31'd0, pop}, 32'd1);
    @(negedge clk);
    chk("midpop_op0_before", op0, 32'd7);
    rst = 1'b1;
    #1;
    chk("midpop_pop", {31'd0, pop}, 32'd0);
    chk("midpop_running", {31'd0, running}, 32'd0);
    chk("midpop_progaddr", {16'd0, progaddr}, 32'd0);
    chk("midpop_op0_cleared", op0, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_progaddr", {16'd0, progaddr}, 32'd0);
    chk("restart_running", {31'd0, running}, 32'd1);
    wait_halt("restart");
    chk("restart_pc", {16'd0, progaddr}, 32'd1);
    chk("restart_pushes", push_cnt, 1);
    chk("restart_push_val", last_push, 32'd12);
    chk("restart_ops", {op0[15:0], op1[15:0]}, {16'd7, 16'd5});
    pulse_start();
    chk("from_halt_progaddr", {16'd0, progaddr}, 32'd0);
    chk("from_halt_running", {31'd0, running}, 32'd1);
    wait_halt("from_halt");
    chk("from_halt_pc", {16'd0, progaddr}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
